// File: rtl/ft600_mode245.sv
// FT600 245-mode synchronous FIFO bridge. The FT600 pins are sampled in the clk domain,
// and 16-bit bus words are moved to and from byte ring buffers.
module ft600_mode245 #(
  parameter int RX_BUFFER       = 16,
  parameter int TX_BUFFER       = 16,
  parameter int RX_BUFFER_WIDTH = $clog2(RX_BUFFER),
  parameter int TX_BUFFER_WIDTH = $clog2(TX_BUFFER)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [8*RX_BUFFER-1:0]     rx_buf,
  output logic [RX_BUFFER_WIDTH-1:0] rx_buf_written,
  input  logic [8*TX_BUFFER-1:0]     tx_buf,
  input  logic [TX_BUFFER_WIDTH-1:0] tx_buf_send,
  output logic [TX_BUFFER_WIDTH-1:0] tx_buf_sent,
  input  logic                       ft_clk,
  inout  wire  [15:0]                ft_data,
  inout  wire  [1:0]                 ft_be,
  input  logic                       ft_txe,
  input  logic                       ft_rxf,
  output logic                       ft_oe,
  output logic                       ft_rd,
  output logic                       ft_wr
);

  localparam int SW = 21;
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b1, 1'b1, 2'b00, 16'h0000};
  localparam logic [RX_BUFFER_WIDTH-1:0] RX_ONE  = {{(RX_BUFFER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RX_BUFFER_WIDTH-1:0] RX_ZERO = {RX_BUFFER_WIDTH{1'b0}};
  localparam logic [TX_BUFFER_WIDTH-1:0] TX_ONE  = {{(TX_BUFFER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TX_BUFFER_WIDTH-1:0] TX_ZERO = {TX_BUFFER_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX_OE = 2'd1,
    RX_RD = 2'd2,
    TX    = 2'd3
  } state_e;

  function automatic logic [7:0] tx_byte(input logic [8*TX_BUFFER-1:0] ring,
                                         input logic [TX_BUFFER_WIDTH-1:0] idx);
    return ring[8*idx +: 8];
  endfunction

  // Returns {be, data} for the word starting at 'start' with 'pend' bytes available.
  function automatic logic [17:0] tx_word(input logic [8*TX_BUFFER-1:0]     ring,
                                          input logic [TX_BUFFER_WIDTH-1:0] start,
                                          input logic [TX_BUFFER_WIDTH-1:0] pend);
    logic [17:0] w;
    if (pend > TX_ONE) begin
      w = {2'b11, tx_byte(ring, start + TX_ONE), tx_byte(ring, start)};
    end else begin
      w = {2'b01, 8'h00, tx_byte(ring, start)};
    end
    return w;
  endfunction

  logic [SW-1:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic                       clk_prev_q, clk_prev_d;
  logic                       ft_clk_s, txe_s, rxf_s, tick_s;
  logic [1:0]                 be_s;
  logic [15:0]                data_s;
  state_e                     state_q, state_d;
  logic                       oe_q, oe_d, rd_q, rd_d, wr_q, wr_d, drive_q, drive_d;
  logic [15:0]                dout_q, dout_d;
  logic [1:0]                 be_out_q, be_out_d;
  logic [TX_BUFFER_WIDTH-1:0] sent_q, sent_d, pending_s, sent_commit_s, pending_commit_s;
  logic [17:0]                word_idle_s, word_next_s;
  logic [RX_BUFFER_WIDTH-1:0] wr_idx_q, wr_idx_d, rx_idx_s;
  logic [8*RX_BUFFER-1:0]     rx_buf_q, rx_buf_d;

  // Two-flop synchronizers for every FT600 input, plus the ft_clk history for edge detection.
  always_comb begin
    sync1_d    = {ft_clk, ft_txe, ft_rxf, ft_be, ft_data};
    sync2_d    = sync1_q;
    clk_prev_d = ft_clk_s;
  end

  assign {ft_clk_s, txe_s, rxf_s, be_s, data_s} = sync2_q;
  assign tick_s = clk_prev_q & ~ft_clk_s;

  // Bus FSM: all strobe, data and index updates happen only on a detected ft_clk fall.
  always_comb begin
    state_d          = state_q;
    oe_d             = oe_q;
    rd_d             = rd_q;
    wr_d             = wr_q;
    drive_d          = drive_q;
    dout_d           = dout_q;
    be_out_d         = be_out_q;
    sent_d           = sent_q;
    wr_idx_d         = wr_idx_q;
    rx_buf_d         = rx_buf_q;
    rx_idx_s         = wr_idx_q;
    pending_s        = tx_buf_send - sent_q;
    sent_commit_s    = sent_q + TX_ONE + (be_out_q[1] ? TX_ONE : TX_ZERO);
    pending_commit_s = tx_buf_send - sent_commit_s;
    word_idle_s      = tx_word(tx_buf, sent_q, pending_s);
    word_next_s      = tx_word(tx_buf, sent_commit_s, pending_commit_s);
    if (tick_s) begin
      case (state_q)
        IDLE: begin
          if (rxf_s == 1'b0) begin
            state_d = RX_OE;
            oe_d    = 1'b0;
          end else if (txe_s == 1'b0 && pending_s != TX_ZERO) begin
            state_d              = TX;
            wr_d                 = 1'b0;
            drive_d              = 1'b1;
            {be_out_d, dout_d}   = word_idle_s;
          end else begin
            state_d = IDLE;
          end
        end
        RX_OE: begin
          state_d = RX_RD;
          rd_d    = 1'b0;
        end
        RX_RD: begin
          if (rxf_s == 1'b0) begin
            if (be_s[0]) begin
              rx_buf_d[8*rx_idx_s +: 8] = data_s[7:0];
              rx_idx_s                  = rx_idx_s + RX_ONE;
            end else begin
              rx_idx_s = rx_idx_s + RX_ZERO;
            end
            if (be_s[1]) begin
              rx_buf_d[8*rx_idx_s +: 8] = data_s[15:8];
              rx_idx_s                  = rx_idx_s + RX_ONE;
            end else begin
              rx_idx_s = rx_idx_s + RX_ZERO;
            end
            wr_idx_d = rx_idx_s;
          end else begin
            rd_d    = 1'b1;
            oe_d    = 1'b1;
            state_d = IDLE;
          end
        end
        TX: begin
          // The word on the bus since the previous tick has been taken by the FT600.
          sent_d = sent_commit_s;
          if (txe_s == 1'b0 && pending_commit_s != TX_ZERO) begin
            {be_out_d, dout_d} = word_next_s;
          end else begin
            wr_d    = 1'b1;
            drive_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b1;
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          drive_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      clk_prev_q <= 1'b0;
      state_q    <= IDLE;
      oe_q       <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      drive_q    <= 1'b0;
      dout_q     <= 16'h0000;
      be_out_q   <= 2'b00;
      sent_q     <= TX_ZERO;
      wr_idx_q   <= RX_ZERO;
      rx_buf_q   <= {(8*RX_BUFFER){1'b0}};
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      oe_q       <= oe_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      drive_q    <= drive_d;
      dout_q     <= dout_d;
      be_out_q   <= be_out_d;
      sent_q     <= sent_d;
      wr_idx_q   <= wr_idx_d;
      rx_buf_q   <= rx_buf_d;
    end
  end

  assign rx_buf         = rx_buf_q;
  assign rx_buf_written = wr_idx_q;
  assign tx_buf_sent    = sent_q;
  assign ft_oe          = oe_q;
  assign ft_rd          = rd_q;
  assign ft_wr          = wr_q;
  assign ft_data        = drive_q ? dout_q : 16'hzzzz;
  assign ft_be          = drive_q ? be_out_q : 2'bzz;

endmodule

// File: tb/tb_ft600_mode245.sv
// Directed bench for ft600_mode245: a behavioural FT600 answers the strobes, and
// queued expectations are checked as words and bytes come out of the bridge.
module tb_ft600_mode245;

  typedef struct packed {logic [15:0] d; logic [1:0] be;} txw_t;
  typedef struct packed {logic [3:0] idx; logic [7:0] b;} rxb_t;

  logic         clk, rst_n, ft_clk;
  logic [127:0] rx_buf, tx_buf;
  logic [3:0]   rx_buf_written, tx_buf_send, tx_buf_sent;
  wire  [15:0]  ft_data;
  wire  [1:0]   ft_be;
  logic         ft_txe, ft_rxf, ft_oe, ft_rd, ft_wr;

  int n_cmp = 0, n_fail = 0;
  logic [15:0] rx_q[$];
  logic [1:0]  rxbe_q[$];
  txw_t        tx_exp[$];
  rxb_t        rx_exp[$];
  logic [7:0]  tx_mem[16];
  logic [15:0] rx_word;
  logic [1:0]  rx_be_w;
  logic        rxf_n, txe_n;
  logic [3:0]  rx_idx;
  int tx_space, tx_accepted, tx_extra, oe_only_edges, edge_cnt, last_oe_edge, first_wr_edge;

  ft600_mode245 dut (
    .clk(clk), .rst_n(rst_n), .rx_buf(rx_buf), .rx_buf_written(rx_buf_written),
    .tx_buf(tx_buf), .tx_buf_send(tx_buf_send), .tx_buf_sent(tx_buf_sent),
    .ft_clk(ft_clk), .ft_data(ft_data), .ft_be(ft_be), .ft_txe(ft_txe), .ft_rxf(ft_rxf),
    .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr)
  );

  assign ft_txe  = txe_n;
  assign ft_rxf  = rxf_n;
  assign ft_data = (ft_oe == 1'b0) ? rx_word : 16'hzzzz;
  assign ft_be   = (ft_oe == 1'b0) ? rx_be_w : 2'bzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial ft_clk = 1'b0;
  always #40 ft_clk = ~ft_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FT600 side: acts on its rising clock edge from the strobes it sees there.
  task automatic ft_model();
    txw_t e;
    forever begin
      @(posedge ft_clk);
      edge_cnt++;
      if (ft_oe == 1'b0) last_oe_edge = edge_cnt;
      if (ft_oe == 1'b0 && ft_rd == 1'b1) oe_only_edges++;
      if (ft_wr == 1'b0 && first_wr_edge < 0) first_wr_edge = edge_cnt;
      if (ft_oe == 1'b0 && ft_rd == 1'b0 && rxf_n == 1'b0) begin
        if (rx_q.size() > 0) begin
          rx_word = rx_q.pop_front();
          rx_be_w = rxbe_q.pop_front();
        end else begin
          rxf_n = 1'b1;
        end
      end
      if (ft_wr == 1'b0 && txe_n == 1'b0) begin
        tx_accepted++;
        if (tx_exp.size() > 0) begin
          e = tx_exp.pop_front();
          check("tx_word_data", {16'h0000, ft_data}, {16'h0000, e.d});
          check("tx_word_be", {30'd0, ft_be}, {30'd0, e.be});
        end else begin
          tx_extra++;
        end
        if (tx_space > 0) tx_space--;
        txe_n = (tx_space == 0);
      end
    end
  endtask

  task automatic set_tx_mem(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      tx_mem[i] = base + 8'(i);
      tx_buf[8*i +: 8] = base + 8'(i);
    end
  endtask

  task automatic push_tx(input logic [3:0] s, input logic [3:0] e);
    logic [3:0] p;
    txw_t w;
    p = e - s;
    while (p != 4'd0) begin
      if (p >= 4'd2) begin
        w.d = {tx_mem[s + 4'd1], tx_mem[s]}; w.be = 2'b11; s = s + 4'd2; p = p - 4'd2;
      end else begin
        w.d = {8'h00, tx_mem[s]}; w.be = 2'b01; s = s + 4'd1; p = p - 4'd1;
      end
      tx_exp.push_back(w);
    end
  endtask

  task automatic push_rx(input logic [15:0] w, input logic [1:0] be);
    rx_q.push_back(w);
    rxbe_q.push_back(be);
    if (be[0]) begin rx_exp.push_back({rx_idx, w[7:0]}); rx_idx = rx_idx + 4'd1; end
    if (be[1]) begin rx_exp.push_back({rx_idx, w[15:8]}); rx_idx = rx_idx + 4'd1; end
  endtask

  task automatic wait_rx_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk);
      done = (rxf_n == 1'b1 && ft_oe == 1'b1 && ft_rd == 1'b1);
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_rx_sb(input string tag);
    rxb_t e;
    while (rx_exp.size() > 0) begin
      e = rx_exp.pop_front();
      check(tag, {24'd0, rx_buf[8*e.idx +: 8]}, {24'd0, e.b});
    end
    check({tag, "_written"}, {28'd0, rx_buf_written}, {28'd0, rx_idx});
  endtask

  task automatic wait_tx(input logic [3:0] target, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk);
      done = (tx_buf_sent == target && ft_wr == 1'b1);
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; tx_buf_send = 4'd0; rxf_n = 1'b1; txe_n = 1'b1; tx_space = 0;
    rx_word = 16'h0000; rx_be_w = 2'b00; rx_idx = 4'd0; tx_accepted = 0; tx_extra = 0;
    oe_only_edges = 0; edge_cnt = 0; last_oe_edge = 0; first_wr_edge = -1;
    tx_buf = 128'd0;
    set_tx_mem(8'h00);
    fork ft_model(); join_none
    repeat (5) @(negedge clk);
    check("rst_oe", {31'd0, ft_oe}, 32'd1);
    check("rst_rd", {31'd0, ft_rd}, 32'd1);
    check("rst_wr", {31'd0, ft_wr}, 32'd1);
    check("rst_sent", {28'd0, tx_buf_sent}, 32'd0);
    check("rst_written", {28'd0, rx_buf_written}, 32'd0);
    check("rst_rx_buf", {31'd0, (rx_buf == 128'd0)}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // RX: three full words
    push_rx(16'h0201, 2'b11); push_rx(16'h0403, 2'b11); push_rx(16'h0605, 2'b11);
    rxf_n = 1'b0;
    wait_rx_done("rx3_done");
    check_rx_sb("rx3");
    check("rx3_oe_before_rd", oe_only_edges, 32'd1);

    // RX: odd final word stores only its low byte
    push_rx(16'h0807, 2'b11); push_rx(16'h0009, 2'b01);
    rxf_n = 1'b0;
    wait_rx_done("rx_odd_done");
    check_rx_sb("rx_odd");
    check("rx_odd_hi_unwritten", {24'd0, rx_buf[79:72]}, 32'd0);

    push_rx(16'h0B0A, 2'b11); push_rx(16'h0D0C, 2'b11); push_rx(16'h000E, 2'b01);
    rxf_n = 1'b0;
    wait_rx_done("rx_to14_done");
    check_rx_sb("rx_to14");

    // RX wrap from index 14
    push_rx(16'h1110, 2'b11); push_rx(16'h1312, 2'b11);
    rxf_n = 1'b0;
    wait_rx_done("rx_wrap_done");
    check_rx_sb("rx_wrap");

    // TX: five bytes in one burst
    tx_space = 100; txe_n = 1'b0; tx_accepted = 0;
    push_tx(4'd0, 4'd5);
    tx_buf_send = 4'd5;
    wait_tx(4'd5, "tx5_done");
    check("tx5_words_left", tx_exp.size(), 32'd0);
    check("tx5_accepted", tx_accepted, 32'd3);

    // TX stall after one word, then resume
    tx_space = 1;
    push_tx(4'd5, 4'd11);
    tx_buf_send = 4'd11;
    wait_tx(4'd7, "stall_sent");
    repeat (40) @(negedge clk);
    check("stall_sent_held", {28'd0, tx_buf_sent}, 32'd7);
    check("stall_wr_high", {31'd0, ft_wr}, 32'd1);
    check("stall_words_left", tx_exp.size(), 32'd2);
    tx_space = 100; txe_n = 1'b0;
    wait_tx(4'd11, "resume_done");
    check("resume_words_left", tx_exp.size(), 32'd0);

    // TX across the ring wrap
    push_tx(4'd11, 4'd15);
    tx_buf_send = 4'd15;
    wait_tx(4'd15, "tx_to15_done");
    set_tx_mem(8'hA0);
    push_tx(4'd15, 4'd1);
    tx_buf_send = 4'd1;
    wait_tx(4'd1, "tx_wrap_done");
    check("tx_wrap_words_left", tx_exp.size(), 32'd0);

    // Priority: RX and TX ready together; set just after a tick so both are seen at once
    @(negedge ft_clk);
    repeat (4) @(negedge clk);
    first_wr_edge = -1;
    push_rx(16'h2221, 2'b11); push_rx(16'h2423, 2'b11);
    push_tx(4'd1, 4'd4);
    rxf_n = 1'b0; txe_n = 1'b0; tx_space = 100;
    tx_buf_send = 4'd4;
    wait_rx_done("prio_rx_done");
    check_rx_sb("prio_rx");
    wait_tx(4'd4, "prio_tx_done");
    check("prio_idle_gap", {31'd0, (first_wr_edge - last_oe_edge >= 2)}, 32'd1);
    check("prio_tx_words_left", tx_exp.size(), 32'd0);

    // Reset in the middle of a TX burst
    push_tx(4'd4, 4'd14);
    tx_buf_send = 4'd14;
    begin
      bit started = 1'b0;
      for (int i = 0; i < 400 && !started; i++) begin
        @(negedge clk);
        started = (ft_wr == 1'b0);
      end
      check("rst_tx_started", {31'd0, started}, 32'd1);
    end
    @(posedge ft_clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_wr", {31'd0, ft_wr}, 32'd1);
    check("midrst_oe", {31'd0, ft_oe}, 32'd1);
    check("midrst_rd", {31'd0, ft_rd}, 32'd1);
    check("midrst_sent", {28'd0, tx_buf_sent}, 32'd0);
    check("midrst_written", {28'd0, rx_buf_written}, 32'd0);
    check("midrst_rx_buf", {31'd0, (rx_buf == 128'd0)}, 32'd1);
    tx_buf_send = 4'd0; txe_n = 1'b1; tx_space = 0;
    tx_exp.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_sent", {28'd0, tx_buf_sent}, 32'd0);
    check("post_rst_wr", {31'd0, ft_wr}, 32'd1);
    check("tx_no_extra_words", tx_extra, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
